// File: rtl/fusion_pkg.sv
// Shared parameters, state encoding and lane helpers for the feature defusion path.
package fusion_pkg;

   localparam int unsigned LANES     = 6;
   localparam int unsigned ELEM_W    = 32;
   localparam int unsigned FRAC_BITS = 16;
   localparam int unsigned WEIGHT_W  = 64;
   localparam int unsigned PAD_W     = 320;
   localparam int unsigned FEAT_W    = LANES * ELEM_W;
   localparam int unsigned FUSED_W   = FEAT_W + PAD_W;
   localparam int unsigned DVD_W     = ELEM_W + FRAC_BITS;
   localparam int unsigned LANE_W    = 3;
   localparam int unsigned DIV_CNT_W = 6;

   localparam logic [ELEM_W-1:0] Q_MAX = 32'h7FFF_FFFF;
   localparam logic [ELEM_W-1:0] Q_MIN = 32'h8000_0000;

   typedef enum logic [2:0] {IDLE, LOAD, DIV, STORE, OUT} state_e;

   // Magnitude of a signed element; 0x8000_0000 maps to 2^31 without overflow.
   function automatic logic [ELEM_W-1:0] mag_elem(input logic [ELEM_W-1:0] x);
      return x[ELEM_W-1] ? ELEM_W'(-x) : x;
   endfunction

   // Apply the result sign to a magnitude quotient and clamp to signed Q16.16.
   function automatic logic [ELEM_W-1:0] sat_lane(input logic [DVD_W-1:0] qmag,
                                                  input logic             neg);
      if (qmag == '0)
         return '0;
      if (neg)
         return (qmag > DVD_W'(Q_MIN)) ? Q_MIN : ELEM_W'(-qmag);
      return (qmag > DVD_W'(Q_MAX)) ? Q_MAX : ELEM_W'(qmag);
   endfunction

endpackage

// File: rtl/seq_div_u48.sv
// Unsigned radix-2 restoring divider: 48-bit dividend by 64-bit divisor,
// one quotient bit per cycle for 48 cycles after start.
module seq_div_u48
   import fusion_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [DVD_W-1:0]    dividend,
   input  logic [WEIGHT_W-1:0] divisor,
   output logic                busy,
   output logic                done_c,
   output logic [DVD_W-1:0]    quotient
);

   logic                 busy_q, busy_d;
   logic [DIV_CNT_W-1:0] cnt_q, cnt_d;
   logic [WEIGHT_W-1:0]  rem_q, rem_d;
   logic [WEIGHT_W-1:0]  dvs_q, dvs_d;
   logic [DVD_W-1:0]     quo_q, quo_d;
   logic [WEIGHT_W:0]    shifted_c;

   // quo_q shifts dividend bits out of the top while quotient bits enter at the bottom
   always_comb begin
      busy_d    = busy_q;
      cnt_d     = cnt_q;
      rem_d     = rem_q;
      dvs_d     = dvs_q;
      quo_d     = quo_q;
      shifted_c = {rem_q, quo_q[DVD_W-1]};
      if (start) begin
         busy_d = 1'b1;
         cnt_d  = '0;
         rem_d  = '0;
         dvs_d  = divisor;
         quo_d  = dividend;
      end else if (busy_q) begin
         if (shifted_c >= {1'b0, dvs_q}) begin
            rem_d = WEIGHT_W'(shifted_c - {1'b0, dvs_q});
            quo_d = {quo_q[DVD_W-2:0], 1'b1};
         end else begin
            rem_d = shifted_c[WEIGHT_W-1:0];
            quo_d = {quo_q[DVD_W-2:0], 1'b0};
         end
         cnt_d = DIV_CNT_W'(cnt_q + 1'b1);
         if (cnt_q == DIV_CNT_W'(DVD_W - 1))
            busy_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q <= 1'b0;
         cnt_q  <= '0;
         rem_q  <= '0;
         dvs_q  <= '0;
         quo_q  <= '0;
      end else begin
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
         rem_q  <= rem_d;
         dvs_q  <= dvs_d;
         quo_q  <= quo_d;
      end
   end

   // High during the final iteration cycle; quotient is complete after this edge.
   assign done_c   = busy_q && (cnt_q == DIV_CNT_W'(DVD_W - 1));
   assign busy     = busy_q;
   assign quotient = quo_q;

endmodule

// File: rtl/feature_defusion.sv
// Recovers six unscaled Q16.16 elements from a fused feature by dividing each
// lane by the attention weight through one shared sequential divider.
module feature_defusion
   import fusion_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [FUSED_W-1:0]  fused_feature,
   input  logic [WEIGHT_W-1:0] attention_weight,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [FEAT_W-1:0]   V,
   output logic                div_by_zero,
   output logic                pad_error
);

   state_e                           state_q, state_d;
   logic [LANE_W-1:0]                lane_q, lane_d;
   logic [DIV_CNT_W-1:0]             div_cnt_q, div_cnt_d;
   logic [LANES-1:0][ELEM_W-1:0]     feat_q, feat_d;
   logic [LANES-1:0][ELEM_W-1:0]     v_q, v_d;
   logic [WEIGHT_W-1:0]              wt_q, wt_d;
   logic dz_q, dz_d, pad_q, pad_d;
   logic neg_q, neg_d, src_neg_q, src_neg_d, src_zero_q, src_zero_d;
   logic in_ready_q, in_ready_d, out_valid_q, out_valid_d;

   logic [ELEM_W-1:0]   elem_c;
   logic [DVD_W-1:0]    dividend_c;
   logic [WEIGHT_W-1:0] divisor_c;
   logic [DVD_W-1:0]    quotient;
   logic                div_start_c, div_busy, div_done_c;

   assign elem_c     = feat_q[lane_q];
   assign dividend_c = {mag_elem(elem_c), FRAC_BITS'(0)};
   assign divisor_c  = wt_q[WEIGHT_W-1] ? WEIGHT_W'(-wt_q) : wt_q;

   seq_div_u48 u_div (
      .clk      (clk),
      .rst      (rst),
      .start    (div_start_c),
      .dividend (dividend_c),
      .divisor  (divisor_c),
      .busy     (div_busy),
      .done_c   (div_done_c),
      .quotient (quotient)
   );

   always_comb begin
      state_d     = state_q;
      lane_d      = lane_q;
      div_cnt_d   = div_cnt_q;
      feat_d      = feat_q;
      v_d         = v_q;
      wt_d        = wt_q;
      dz_d        = dz_q;
      pad_d       = pad_q;
      neg_d       = neg_q;
      src_neg_d   = src_neg_q;
      src_zero_d  = src_zero_q;
      div_start_c = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (in_valid && in_ready_q) begin
               feat_d  = fused_feature[FEAT_W-1:0];
               wt_d    = attention_weight;
               dz_d    = (attention_weight == '0);
               pad_d   = |fused_feature[FUSED_W-1:FEAT_W];
               lane_d  = '0;
               state_d = LOAD;
            end
         end
         LOAD: begin
            neg_d       = elem_c[ELEM_W-1] ^ wt_q[WEIGHT_W-1];
            src_neg_d   = elem_c[ELEM_W-1];
            src_zero_d  = (elem_c == '0);
            div_start_c = !dz_q && !div_busy;
            div_cnt_d   = '0;
            state_d     = DIV;
         end
         // A zero weight leaves the divider idle but keeps the same lane timing
         DIV: begin
            div_cnt_d = DIV_CNT_W'(div_cnt_q + 1'b1);
            if (dz_q ? (div_cnt_q == DIV_CNT_W'(DVD_W - 1)) : div_done_c)
               state_d = STORE;
         end
         STORE: begin
            if (dz_q)
               v_d[lane_q] = src_zero_q ? '0 : (src_neg_q ? Q_MIN : Q_MAX);
            else
               v_d[lane_q] = sat_lane(quotient, neg_q);
            if (lane_q == LANE_W'(LANES - 1)) begin
               state_d = OUT;
            end else begin
               lane_d  = LANE_W'(lane_q + 1'b1);
               state_d = LOAD;
            end
         end
         OUT: begin
            if (out_ready)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      in_ready_d  = (state_d == IDLE);
      out_valid_d = (state_d == OUT);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         lane_q      <= '0;
         div_cnt_q   <= '0;
         feat_q      <= '0;
         v_q         <= '0;
         wt_q        <= '0;
         dz_q        <= 1'b0;
         pad_q       <= 1'b0;
         neg_q       <= 1'b0;
         src_neg_q   <= 1'b0;
         src_zero_q  <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         lane_q      <= lane_d;
         div_cnt_q   <= div_cnt_d;
         feat_q      <= feat_d;
         v_q         <= v_d;
         wt_q        <= wt_d;
         dz_q        <= dz_d;
         pad_q       <= pad_d;
         neg_q       <= neg_d;
         src_neg_q   <= src_neg_d;
         src_zero_q  <= src_zero_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready    = in_ready_q;
   assign out_valid   = out_valid_q;
   assign V           = v_q;
   assign div_by_zero = dz_q;
   assign pad_error   = pad_q;

endmodule

// File: tb/tb_feature_defusion.sv
// Self-checking bench for feature_defusion against an arithmetic reference model.
module tb_feature_defusion;

   localparam int EXP_LAT = 301;   // handshake cycle t -> out_valid in cycle t+301

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [511:0] fused;
   logic [63:0]  weight;
   logic         out_valid;
   logic         out_ready;
   logic [191:0] V;
   logic         div_by_zero;
   logic         pad_error;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   feature_defusion dut (
      .clk              (clk),
      .rst              (rst),
      .in_valid         (in_valid),
      .in_ready         (in_ready),
      .fused_feature    (fused),
      .attention_weight (weight),
      .out_valid        (out_valid),
      .out_ready        (out_ready),
      .V                (V),
      .div_by_zero      (div_by_zero),
      .pad_error        (pad_error)
   );

   // Reference: signed (s * 2^16) / w truncated toward zero, clamped to int32.
   function automatic logic [31:0] ref_lane(input logic [31:0] s, input logic [63:0] w);
      longint signed num, den, q;
      if (w == 64'd0) begin
         if (s == 32'd0) return 32'h0000_0000;
         return s[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      end
      num = longint'(signed'(s)) * 64'sd65536;
      den = signed'(w);
      q   = num / den;
      if (q > 64'sd2147483647) return 32'h7FFF_FFFF;
      if (q < -64'sd2147483648) return 32'h8000_0000;
      return 32'(q);
   endfunction

   task automatic send(input logic [511:0] f, input logic [63:0] w, output int lat);
      int guard;
      @(negedge clk);
      guard = 0;
      while (!in_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      fused    = f;
      weight   = w;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 400) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic consume();
      @(negedge clk);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      fused = '0;
      weight = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      total += 5;
      if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      if (V !== 192'd0) begin bad++; $display("FAIL reset_V got=%h exp=0", V); end
      if (div_by_zero !== 1'b0) begin bad++; $display("FAIL reset_dz got=%b exp=0", div_by_zero); end
      if (pad_error !== 1'b0) begin bad++; $display("FAIL reset_pad got=%b exp=0", pad_error); end
   endtask

   task automatic test_directed();
      logic [511:0] f [6];
      logic [63:0]  w [6];
      logic [31:0]  got, exp;
      int lat;
      foreach (f[k]) f[k] = '0;
      for (int i = 0; i < 6; i++) f[0][i*32 +: 32] = 32'h0003_0000;
      w[0] = 64'h0000_0000_0001_0000;
      f[1][31:0] = 32'h0001_0000; f[1][63:32] = 32'hFFFF_0000;
      w[1] = 64'h0000_0000_0002_0000;
      f[2][31:0] = 32'h0001_0000;
      w[2] = 64'hFFFF_FFFF_FFFE_0000;
      f[3][31:0] = 32'hFFFF_FFFF;
      w[3] = 64'h0000_0000_0003_0000;
      f[4][31:0] = 32'h7FFF_0000; f[4][63:32] = 32'h8000_0000;
      w[4] = 64'h0000_0000_0000_0001;
      f[5][63:32] = 32'h0000_0005; f[5][95:64] = 32'hFFFF_FFFB; f[5][300] = 1'b1;
      w[5] = 64'h0;
      for (int c = 0; c < 6; c++) begin
         send(f[c], w[c], lat);
         total++;
         if (lat !== EXP_LAT) begin bad++; $display("FAIL dir%0d_latency got=%0d exp=%0d", c, lat, EXP_LAT); end
         for (int i = 0; i < 6; i++) begin
            got = V[i*32 +: 32];
            exp = ref_lane(f[c][i*32 +: 32], w[c]);
            total++;
            if (got !== exp) begin bad++; $display("FAIL dir%0d_lane%0d got=%h exp=%h", c, i, got, exp); end
         end
         total += 2;
         if (div_by_zero !== (w[c] == 64'd0)) begin bad++; $display("FAIL dir%0d_dz got=%b exp=%b", c, div_by_zero, w[c] == 64'd0); end
         if (pad_error !== (|f[c][511:192])) begin bad++; $display("FAIL dir%0d_pad got=%b exp=%b", c, pad_error, |f[c][511:192]); end
         consume();
         total++;
         if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++; $display("FAIL dir%0d_release in_ready=%b out_valid=%b exp 1/0", c, in_ready, out_valid);
         end
      end
   endtask

   task automatic test_random();
      logic [511:0] f;
      logic [63:0]  w;
      logic [31:0]  got, exp;
      int lat;
      for (int c = 0; c < 8; c++) begin
         f = '0;
         for (int i = 0; i < 6; i++) begin
            case ($urandom_range(0, 5))
               0: f[i*32 +: 32] = 32'h0;
               1: f[i*32 +: 32] = 32'h8000_0000;
               2: f[i*32 +: 32] = 32'($urandom_range(0, 32'h0010_0000));
               default: f[i*32 +: 32] = $urandom;
            endcase
         end
         if ($urandom_range(0, 3) == 0) f[$urandom_range(192, 511)] = 1'b1;
         case ($urandom_range(0, 3))
            0: w = 64'($urandom_range(1, 32'h0004_0000));
            1: w = -64'($urandom_range(1, 32'h0004_0000));
            2: w = {$urandom, $urandom};
            default: w = 64'($urandom_range(1, 16));
         endcase
         send(f, w, lat);
         total++;
         if (lat !== EXP_LAT) begin bad++; $display("FAIL rnd%0d_latency got=%0d exp=%0d", c, lat, EXP_LAT); end
         for (int i = 0; i < 6; i++) begin
            got = V[i*32 +: 32];
            exp = ref_lane(f[i*32 +: 32], w);
            total++;
            if (got !== exp) begin bad++; $display("FAIL rnd%0d_lane%0d got=%h exp=%h w=%h s=%h", c, i, got, exp, w, f[i*32 +: 32]); end
         end
         total += 2;
         if (div_by_zero !== (w == 64'd0)) begin bad++; $display("FAIL rnd%0d_dz got=%b exp=%b", c, div_by_zero, w == 64'd0); end
         if (pad_error !== (|f[511:192])) begin bad++; $display("FAIL rnd%0d_pad got=%b exp=%b", c, pad_error, |f[511:192]); end
         consume();
      end
   endtask

   task automatic test_backpressure();
      logic [511:0] f;
      logic [63:0]  w;
      logic [191:0] exp_v;
      int lat;
      f = '0;
      for (int i = 0; i < 6; i++) f[i*32 +: 32] = $urandom;
      w = 64'($urandom_range(1, 32'h0003_0000));
      for (int i = 0; i < 6; i++) exp_v[i*32 +: 32] = ref_lane(f[i*32 +: 32], w);
      send(f, w, lat);
      total += 2;
      if (lat !== EXP_LAT) begin bad++; $display("FAIL bp_latency got=%0d exp=%0d", lat, EXP_LAT); end
      if (V !== exp_v) begin bad++; $display("FAIL bp_value got=%h exp=%h", V, exp_v); end
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         in_valid = k[0];
         fused    = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         weight   = {$urandom, $urandom};
         total += 3;
         if (V !== exp_v) begin bad++; $display("FAIL bp_hold_V cyc%0d got=%h exp=%h", k, V, exp_v); end
         if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready cyc%0d got=%b exp=0", k, in_ready); end
         if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_out_valid cyc%0d got=%b exp=1", k, out_valid); end
      end
      in_valid = 1'b0;
      consume();
      total += 2;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_release_valid got=%b exp=0", out_valid); end
      if (V !== exp_v) begin bad++; $display("FAIL bp_idle_hold got=%h exp=%h", V, exp_v); end
   endtask

   task automatic test_reset_abort();
      logic [511:0] f;
      logic [63:0]  w;
      logic [191:0] exp_v;
      logic         seen;
      int lat;
      f = '0;
      for (int i = 0; i < 6; i++) f[i*32 +: 32] = 32'h0004_0000 + 32'(i);
      w = 64'h0000_0000_0002_0000;
      @(negedge clk);
      fused = f; weight = w; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (99) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      total += 2;
      if (in_ready !== 1'b1) begin bad++; $display("FAIL abort_in_ready got=%b exp=1", in_ready); end
      if (V !== 192'd0) begin bad++; $display("FAIL abort_V got=%h exp=0", V); end
      seen = 1'b0;
      repeat (400) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      total++;
      if (seen !== 1'b0) begin bad++; $display("FAIL abort_out_valid got=%b exp=0", seen); end
      f[31:0] = 32'hFFFD_0000;
      w = 64'hFFFF_FFFF_FFFF_8000;
      for (int i = 0; i < 6; i++) exp_v[i*32 +: 32] = ref_lane(f[i*32 +: 32], w);
      send(f, w, lat);
      total += 2;
      if (lat !== EXP_LAT) begin bad++; $display("FAIL post_abort_latency got=%0d exp=%0d", lat, EXP_LAT); end
      if (V !== exp_v) begin bad++; $display("FAIL post_abort_value got=%h exp=%h", V, exp_v); end
      consume();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_backpressure();
      test_reset_abort();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/feature_defusion.md
Name: feature_defusion

Overview:
- Inverse of the fusion-core feature scaler.
- Accepts a 512-bit fused feature (six Q16.16 scaled lanes in bits [191:0], zero padding in [511:192]) plus the 64-bit Q16.16 attention weight that produced it.
- Recovers the six unscaled V elements by sequential signed division, one lane at a time, through a shared radix-2 restoring divider.
- Sits on the decode/inspection path after fusion; valid/ready on both sides.

Parameters:
- LANES, 6, number of 32-bit elements.
- ELEM_W, 32, element width (Q16.16).
- FRAC_BITS, 16, fractional bits of element and weight.
- WEIGHT_W, 64, attention weight width (signed Q48.16).

Ports:
- clk  input  1  clock (rising edge).
- rst  input  1  reset; asynchronous, active-high.
- in_valid  input  1  input request.
- in_ready  output  1  block can accept input.
- fused_feature  input  512  fused feature; lane i at [i*32 +: 32].
- attention_weight  input  64  signed Q16.16 weight.
- out_valid  output  1  result available.
- out_ready  input  1  downstream accepts result.
- V  output  192  recovered elements; lane i at [i*32 +: 32], signed Q16.16.
- div_by_zero  output  1  attention_weight was zero for this transaction.
- pad_error  output  1  fused_feature[511:192] was nonzero.

Behaviour:
- Reset: state IDLE, in_ready=1 once rst is low, out_valid=0, V=0, div_by_zero=0, pad_error=0, lane counter=0. rst mid-operation aborts the transaction; no partial result is emitted.
- Accept: in_valid && in_ready in IDLE. Register fused_feature[191:0] and attention_weight; compute pad_error and div_by_zero at capture. in_ready=0 in all non-IDLE states.
- Per lane: quotient = (scaled_i <<< FRAC_BITS) / weight, signed, truncated toward zero.
  - Operate on magnitudes: 48-bit dividend magnitude, 64-bit divisor magnitude.
  - Result sign = sign(scaled_i) XOR sign(weight); a zero quotient is never negated.
  - Saturate the 48-bit magnitude quotient to signed 32-bit: positive > 0x7FFF_FFFF gives 0x7FFF_FFFF; negative magnitude > 0x8000_0000 gives 0x8000_0000.
  - Divide by zero: divider is skipped (STORE still takes its cycle). Lane = 0 if scaled_i = 0; else 0x7FFF_FFFF for positive scaled_i, 0x8000_0000 for negative scaled_i.
- FSM:
  - IDLE -> LOAD on accept.
  - LOAD (1 cycle): compute magnitudes and sign for lane; start divider.
  - DIV (48 cycles): one quotient bit per cycle.
  - STORE (1 cycle): sign-apply, saturate, write V lane. If lane=LANES-1 go to OUT, else lane++ and go to LOAD.
  - OUT: out_valid=1; on out_ready go to IDLE (in_ready=1 the following cycle).
- Latency: accept at cycle t gives out_valid high at t+1+LANES*50 = t+301 (defaults).
- V, div_by_zero and pad_error hold stable from out_valid rise until the handshake. They keep their last values in IDLE until the next STORE or capture overwrites them.
- The 0x8000_0000 input lane is handled as magnitude 2^31; no overflow in the magnitude path.
- pad_error is informational only; computation proceeds on bits [191:0].

Decomposition:
- Package fusion_pkg:
  - LANES, ELEM_W, FRAC_BITS, WEIGHT_W, PAD_W=320.
  - Q16.16 constants Q_MAX=0x7FFF_FFFF, Q_MIN=0x8000_0000.
  - State enum {IDLE, LOAD, DIV, STORE, OUT}.
- One sub-module, seq_div_u48:
  - Unsigned restoring divider, 48-bit dividend / 64-bit divisor.
  - start/busy/done handshake; 48-cycle iteration; 48-bit quotient out.
  - Controlled by the top FSM.

Test Plan:
- weight=0x0000_0000_0001_0000 (1.0), all lanes 0x0003_0000 -> all V lanes 0x0003_0000, flags 0, out_valid at t+301.
- weight=0x0000_0000_0002_0000 (2.0), lane0=0x0001_0000, lane1=0xFFFF_0000 -> V0=0x0000_8000, V1=0xFFFF_8000.
- weight=0xFFFF_FFFF_FFFE_0000 (-2.0), lane0=0x0001_0000; weight=0x...0003_0000 (3.0), lane0=0xFFFF_FFFF -> first gives V0=0xFFFF_8000; second gives V0=0x0000_0000 (truncation toward zero, no negative zero).
- weight=0x1, lane0=0x7FFF_0000, lane1=0x8000_0000 -> V0=0x7FFF_FFFF, V1=0x8000_0000 (saturation).
- weight=0, lanes {0x0000_0000, 0x0000_0005, 0xFFFF_FFFB}, bit 300 set -> V lanes {0, 0x7FFF_FFFF, 0x8000_0000}, div_by_zero=1, pad_error=1.
- Backpressure and reset:
  - Hold out_ready=0 for 20 cycles: V stable, in_ready=0; in_valid pulses are ignored.
  - Assert rst at cycle 100 of a transaction: out_valid never rises; in_ready=1 after rst deasserts; the next transaction returns a correct result.
